// File: rtl/comparator_pkg.sv
// Shared definitions for the serial word comparator: FSM encoding and default word width.
package comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/xnor_gate.sv
// Single-bit equality primitive: y is high when a and b carry the same value.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/serial_word_comparator.sv
// Compares two LSB-first serial operands bit-pair by bit-pair and reports
// equality, the number of mismatching pairs and the index of the first mismatch.
module serial_word_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       bit_valid,
  input  logic                       a,
  input  logic                       b,
  output logic                       busy,
  output logic                       done,
  output logic                       equal,
  output logic [$clog2(WIDTH+1)-1:0] mismatch_cnt,
  output logic [$clog2(WIDTH)-1:0]   first_idx
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  // Handshake: a pair on a/b is consumed on every rising edge where the FSM is
  // in COMPARE and bit_valid is high; there is no back-pressure, busy only
  // tells the source that a word is in flight. start is consumed only in IDLE.

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           equal_q, equal_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  first_q, first_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           pair_match;

  xnor_gate u_match (
    .a (a),
    .b (b),
    .y (pair_match)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    equal_d = equal_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COMPARE;
          busy_d  = 1'b1;
          equal_d = 1'b0;
          cnt_d   = '0;
          first_d = '0;
          idx_d   = '0;
        end
      end
      ST_COMPARE: begin
        if (bit_valid) begin
          if (!pair_match) begin
            cnt_d = cnt_q + CW'(1);
            // A zero count means no earlier mismatch in this word.
            if (cnt_q == '0) first_d = idx_q;
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            equal_d = (cnt_d == '0);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      idx_q   <= idx_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign equal        = equal_q;
  assign mismatch_cnt = cnt_q;
  assign first_idx    = first_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator (WIDTH=8): stimulus pushes expected
// results into a queue, a negedge monitor pops and compares on every done pulse.
module tb_serial_word_comparator;

  localparam int WIDTH = 8;
  localparam int W     = 8;  // {equal, mismatch_cnt[3:0], first_idx[2:0]}

  logic       clk;
  logic       rst;
  logic       start;
  logic       bit_valid;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       equal;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_idx;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  serial_word_comparator #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bit_valid    (bit_valid),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_cnt (mismatch_cnt),
    .first_idx    (first_idx)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_equal", 32'(equal), 32'(e[7]));
          check("result_cnt", 32'(mismatch_cnt), 32'(e[6:3]));
          check("result_first", 32'(first_idx), 32'(e[2:0]));
          check("done_busy_low", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Drivers
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_pairs(input logic [7:0] av, input logic [7:0] bv, input int n,
                            input bit gaps, input int repulse_at);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bit_valid = 1'b0;
        a = ~av[i];
        b = bv[i];
        @(posedge clk); #1;
      end
      bit_valid = 1'b1;
      a = av[i];
      b = bv[i];
      start = (i == repulse_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (i < WIDTH - 1) check("busy_mid_word", 32'(busy), 32'd1);
    end
    bit_valid = 1'b0;
  endtask

  task automatic run_word(input logic [7:0] av, input logic [7:0] bv, input bit gaps,
                          input int repulse_at, input logic eq, input logic [3:0] cnt,
                          input logic [2:0] fi);
    exp_q.push_back({eq, cnt, fi});
    pulse_start();
    send_pairs(av, bv, WIDTH, gaps, repulse_at);
    check("done_latency", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("done_single_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    a = 1'b0;
    b = 1'b0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_equal", 32'(equal), 32'd0);
    check("reset_cnt", 32'(mismatch_cnt), 32'd0);
    check("reset_first", 32'(first_idx), 32'd0);
    rst = 1'b0;

    // bit_valid in IDLE must not start or disturb anything
    @(posedge clk); #1;
    bit_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bit_valid = 1'b0;
    check("idle_valid_ignored", 32'(busy), 32'd0);

    run_word(8'h5A, 8'h5A, 1'b0, -1, 1'b1, 4'd0, 3'd0);
    run_word(8'hA5, 8'hA4, 1'b0, -1, 1'b0, 4'd1, 3'd0);
    run_word(8'hFF, 8'h00, 1'b1, -1, 1'b0, 4'd8, 3'd0);
    run_word(8'h80, 8'h00, 1'b0, 3,  1'b0, 4'd1, 3'd7);
    run_word(8'h00, 8'h28, 1'b0, -1, 1'b0, 4'd2, 3'd3);
    run_word(8'h3C, 8'hC3, 1'b1, -1, 1'b0, 4'd8, 3'd0);

    // Reset mid-word: partial word discarded, outputs clear without a clock edge
    pulse_start();
    send_pairs(8'hF0, 8'h0F, 4, 1'b0, -1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_equal", 32'(equal), 32'd0);
    check("midrst_cnt", 32'(mismatch_cnt), 32'd0);
    check("midrst_first", 32'(first_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_word(8'h3C, 8'h3C, 1'b0, -1, 1'b1, 4'd0, 3'd0);

    // Results hold while idle
    run_word(8'h00, 8'h60, 1'b0, -1, 1'b0, 4'd2, 3'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_done", 32'(done), 32'd0);
      check("hold_equal", 32'(equal), 32'd0);
      check("hold_cnt", 32'(mismatch_cnt), 32'd2);
      check("hold_first", 32'(first_idx), 32'd5);
    end

    repeat (3) @(posedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
